stage0_trace_checker: RTL and testbench
=======================================

STAGE0_TRACE_CHECKER -- requirements
Module: stage0_trace_checker

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width.
REQ-002 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-003 SHALL have parameter FENCE_TMO, default 1024, max cycles rg_fence may stay high.
REQ-004 CLK  in  1  clock; all logic on posedge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 smp_valid  in  1  snapshot fields below valid this cycle.
REQ-007 rg_pc, rg_pc_d_in  in  XLEN each  current fetch PC; next-PC data input.
REQ-008 rg_pc_en  in  1  PC register write enable.
REQ-009 rg_eepoch, rg_wepoch  in  1 each  execute/writeback epoch bits.
REQ-010 en_upd_eepoch, en_upd_wepoch  in  1 each  epoch toggle requests.
REQ-011 rg_fence, rg_sfence, ma_flush  in  1 each  fence pending; sfence pending; flush strobe.
REQ-012 clear_err  in  1  clears sticky errors and first-error capture.
REQ-013 err_pc, err_eepoch, err_wepoch, err_fence_tmo  out  1 each  sticky violation flags.
REQ-014 err_any  out  1  OR of the four error flags.
REQ-015 first_err_pc  out  XLEN  rg_pc of the snapshot raising the first error since reset/clear.
REQ-016 flush_cnt, pc_upd_cnt  out  CNT_W each  saturating counts of ma_flush, rg_pc_en.
REQ-017 fsm_state  out  2  fence FSM state, debug.

Function
REQ-018 SHALL evaluate only snapshots with smp_valid=1; all state frozen when smp_valid=0.
REQ-019 On valid snapshot with rg_pc_en=1: SHALL store exp_pc=rg_pc_d_in, set chk_pc_pend=1.
REQ-020 On next valid snapshot with chk_pc_pend=1: SHALL set err_pc if rg_pc != exp_pc; clear chk_pc_pend unless rg_pc_en=1 again (then reload, back-to-back).
REQ-021 On valid snapshot, SHALL store prev eEpoch and expected toggle (en_upd_eepoch); next valid snapshot: err_eepoch if rg_eepoch != prev ^ toggle.
REQ-022 REQ-021 SHALL apply identically to wEpoch with en_upd_wepoch/err_wepoch.
REQ-023 First valid snapshot after reset/clear_err SHALL only arm REQ-019..022 history, no compare.
REQ-024 Fence FSM states IDLE(0), FENCE(1), SFENCE(2), TMO(3).
REQ-025 IDLE->FENCE on rg_fence=1; IDLE->SFENCE on rg_sfence=1 with rg_fence=0; both high -> FENCE.
REQ-026 FENCE/SFENCE->IDLE when the respective pending bit drops; wait counter clears on entry.
REQ-027 FENCE/SFENCE: wait counter increments per valid snapshot; reaching FENCE_TMO -> TMO, set err_fence_tmo.
REQ-028 TMO->IDLE when rg_fence=0 and rg_sfence=0.
REQ-029 ma_flush and rg_pc_en in same snapshot: both counters increment; PC check still armed per REQ-019.
REQ-030 Counters SHALL saturate at 2^CNT_W-1, never wrap; clear_err does not clear them.
REQ-031 first_err_pc SHALL latch only when err_any was 0 and any error sets this cycle; simultaneous errors latch once.
REQ-032 clear_err=1 SHALL clear errors, first_err_pc, pending history; error detected same cycle is discarded.
REQ-033 All outputs registered; error flags visible the cycle after the violating snapshot.

Reset
REQ-034 RST_N=0 SHALL force: errors 0, err_any 0, first_err_pc 0, counters 0, fsm_state IDLE, wait counter 0, pend/history cleared.
REQ-035 Reset mid-fence or mid-pending SHALL drop all state; first snapshot after reset treated per REQ-023.

Structure
REQ-036 Package stage0_chk_pkg SHALL hold fence FSM state enum and default FENCE_TMO constant.
REQ-037 Saturating counter SHALL be sub-module sat_counter (parameter W; inc, clr, cnt), instantiated twice.

Verification
REQ-038 pc_en=1,d_in=0x8000_0004; next rg_pc=0x8000_0004 -> err_pc=0; repeat with 0x8000_0008 -> err_pc=1, first_err_pc=0x8000_0008.
REQ-039 en_upd_eepoch=1, eEpoch 0; next eEpoch stays 0 -> err_eepoch=1; toggle to 1 -> no error.
REQ-040 rg_fence high 1024 valid snapshots (FENCE_TMO=1024) -> fsm_state=3, err_fence_tmo=1; 1023 then drop -> no error, IDLE.
REQ-041 CNT_W=4, 20 flush strobes -> flush_cnt=15; clear_err -> still 15.
REQ-042 err_pc then err_wepoch, then clear_err with new violation same cycle -> all flags 0, first_err_pc=0.
REQ-043 RST_N=0 while FSM=FENCE with pc check pending -> all outputs 0/IDLE next cycle; first post-reset snapshot raises no error.

Source files
------------

// File: rtl/stage0_chk_pkg.sv
// Shared types for the stage-0 trace checker.
// Fence FSM encoding and the default fence timeout.
package stage0_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FENCE  = 2'd1,
    ST_SFENCE = 2'd2,
    ST_TMO    = 2'd3
  } fence_st_e;

  localparam int FENCE_TMO_DEF = 1024;

endpackage

// File: rtl/stage0_trace_checker_sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/stage0_trace_checker.sv
// Stage-0 trace checker: PC/epoch consistency,
// fence timeout watchdog and event counters.
module stage0_trace_checker
  import stage0_chk_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int CNT_W     = 16,
  parameter int FENCE_TMO = FENCE_TMO_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             smp_valid,
  input  logic [XLEN-1:0]  rg_pc,
  input  logic [XLEN-1:0]  rg_pc_d_in,
  input  logic             rg_pc_en,
  input  logic             rg_eepoch,
  input  logic             rg_wepoch,
  input  logic             en_upd_eepoch,
  input  logic             en_upd_wepoch,
  input  logic             rg_fence,
  input  logic             rg_sfence,
  input  logic             ma_flush,
  input  logic             clear_err,
  output logic             err_pc,
  output logic             err_eepoch,
  output logic             err_wepoch,
  output logic             err_fence_tmo,
  output logic             err_any,
  output logic [XLEN-1:0]  first_err_pc,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] pc_upd_cnt,
  output logic [1:0]       fsm_state
);

  localparam int TW = $clog2(FENCE_TMO + 1);
  // Entry snapshot counts as the first high one.
  localparam logic [TW-1:0] TMO_LIM = TW'(FENCE_TMO - 1);

  fence_st_e       r_fsm;
  logic [TW-1:0]   r_wait;
  logic            r_armed;
  logic            r_pc_pend;
  logic [XLEN-1:0] r_exp_pc;
  logic            r_prev_ee;
  logic            r_tog_ee;
  logic            r_prev_we;
  logic            r_tog_we;
  logic [3:0]      r_err;
  logic            r_err_any;
  logic [XLEN-1:0] r_first_pc;

  fence_st_e       w_fsm_nxt;
  logic [TW-1:0]   w_wait_nxt;
  logic [TW-1:0]   w_wait_inc;
  logic            w_tmo;
  logic            w_pc_err;
  logic            w_ee_err;
  logic            w_we_err;
  logic [3:0]      w_set;

  assign w_wait_inc = r_wait + 1'b1;

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_wait_nxt = r_wait;
    w_tmo      = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (rg_fence) begin
          w_fsm_nxt  = ST_FENCE;
          w_wait_nxt = '0;
        end else if (rg_sfence) begin
          w_fsm_nxt  = ST_SFENCE;
          w_wait_nxt = '0;
        end
      end
      ST_FENCE: begin
        if (!rg_fence) begin
          w_fsm_nxt = ST_IDLE;
        end else if (w_wait_inc == TMO_LIM) begin
          w_fsm_nxt = ST_TMO;
          w_tmo     = 1'b1;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end
      ST_SFENCE: begin
        if (!rg_sfence) begin
          w_fsm_nxt = ST_IDLE;
        end else if (w_wait_inc == TMO_LIM) begin
          w_fsm_nxt = ST_TMO;
          w_tmo     = 1'b1;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end
      ST_TMO: begin
        if (!rg_fence && !rg_sfence) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  assign w_pc_err = r_pc_pend && (rg_pc != r_exp_pc);
  assign w_ee_err = r_armed &&
                    (rg_eepoch != (r_prev_ee ^ r_tog_ee));
  assign w_we_err = r_armed &&
                    (rg_wepoch != (r_prev_we ^ r_tog_we));

  assign w_set = {w_tmo, w_we_err, w_ee_err, w_pc_err}
               & {4{smp_valid & ~clear_err}};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_fsm      <= ST_IDLE;
      r_wait     <= '0;
      r_armed    <= 1'b0;
      r_pc_pend  <= 1'b0;
      r_exp_pc   <= '0;
      r_prev_ee  <= 1'b0;
      r_tog_ee   <= 1'b0;
      r_prev_we  <= 1'b0;
      r_tog_we   <= 1'b0;
      r_err      <= '0;
      r_err_any  <= 1'b0;
      r_first_pc <= '0;
    end else begin
      if (smp_valid) begin
        r_fsm  <= w_fsm_nxt;
        r_wait <= w_wait_nxt;
      end
      if (clear_err) begin
        r_err      <= '0;
        r_err_any  <= 1'b0;
        r_first_pc <= '0;
        r_armed    <= 1'b0;
        r_pc_pend  <= 1'b0;
      end else begin
        r_err     <= r_err | w_set;
        r_err_any <= r_err_any | (|w_set);
        if (!r_err_any && (|w_set)) begin
          r_first_pc <= rg_pc;
        end
        if (smp_valid) begin
          r_armed   <= 1'b1;
          r_pc_pend <= rg_pc_en;
          if (rg_pc_en) begin
            r_exp_pc <= rg_pc_d_in;
          end
          r_prev_ee <= rg_eepoch;
          r_tog_ee  <= en_upd_eepoch;
          r_prev_we <= rg_wepoch;
          r_tog_we  <= en_upd_wepoch;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (smp_valid & ma_flush),
    .clr   (1'b0),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_pc_upd_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (smp_valid & rg_pc_en),
    .clr   (1'b0),
    .cnt   (pc_upd_cnt)
  );

  assign err_pc        = r_err[0];
  assign err_eepoch    = r_err[1];
  assign err_wepoch    = r_err[2];
  assign err_fence_tmo = r_err[3];
  assign err_any       = r_err_any;
  assign first_err_pc  = r_first_pc;
  assign fsm_state     = r_fsm;

endmodule

// File: tb/tb_stage0_trace_checker.sv
// Directed bench for stage0_trace_checker.
// Hand-computed expectations, immediate-assert checks.
module tb_stage0_trace_checker;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST_N;
  logic             smp_valid;
  logic [XLEN-1:0]  rg_pc;
  logic [XLEN-1:0]  rg_pc_d_in;
  logic             rg_pc_en;
  logic             rg_eepoch;
  logic             rg_wepoch;
  logic             en_upd_eepoch;
  logic             en_upd_wepoch;
  logic             rg_fence;
  logic             rg_sfence;
  logic             ma_flush;
  logic             clear_err;
  logic             err_pc;
  logic             err_eepoch;
  logic             err_wepoch;
  logic             err_fence_tmo;
  logic             err_any;
  logic [XLEN-1:0]  first_err_pc;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] pc_upd_cnt;
  logic [1:0]       fsm_state;

  int n_vec;
  int n_bad;

  stage0_trace_checker #(
    .XLEN      (XLEN),
    .CNT_W     (CNT_W),
    .FENCE_TMO (1024)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .smp_valid     (smp_valid),
    .rg_pc         (rg_pc),
    .rg_pc_d_in    (rg_pc_d_in),
    .rg_pc_en      (rg_pc_en),
    .rg_eepoch     (rg_eepoch),
    .rg_wepoch     (rg_wepoch),
    .en_upd_eepoch (en_upd_eepoch),
    .en_upd_wepoch (en_upd_wepoch),
    .rg_fence      (rg_fence),
    .rg_sfence     (rg_sfence),
    .ma_flush      (ma_flush),
    .clear_err     (clear_err),
    .err_pc        (err_pc),
    .err_eepoch    (err_eepoch),
    .err_wepoch    (err_wepoch),
    .err_fence_tmo (err_fence_tmo),
    .err_any       (err_any),
    .first_err_pc  (first_err_pc),
    .flush_cnt     (flush_cnt),
    .pc_upd_cnt    (pc_upd_cnt),
    .fsm_state     (fsm_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One valid snapshot; pulse inputs drop afterwards.
  task automatic snap();
    smp_valid = 1'b1;
    @(posedge CLK);
    #1;
    smp_valid     = 1'b0;
    rg_pc_en      = 1'b0;
    en_upd_eepoch = 1'b0;
    en_upd_wepoch = 1'b0;
    ma_flush      = 1'b0;
    clear_err     = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
    clear_err = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    RST_N = 1'b0;
    smp_valid = 1'b0;
    rg_pc = '0;
    rg_pc_d_in = '0;
    rg_pc_en = 1'b0;
    rg_eepoch = 1'b0;
    rg_wepoch = 1'b0;
    en_upd_eepoch = 1'b0;
    en_upd_wepoch = 1'b0;
    rg_fence = 1'b0;
    rg_sfence = 1'b0;
    ma_flush = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_err_any", 64'(err_any), 64'd0);
    chk("rst_first_pc", first_err_pc, 64'd0);
    chk("rst_fsm", 64'(fsm_state), 64'd0);
    chk("rst_flush", 64'(flush_cnt), 64'd0);
    chk("rst_pcupd", 64'(pc_upd_cnt), 64'd0);
    RST_N = 1'b1;

    // PC prediction: match then mismatch
    rg_pc = 64'h8000_0000;
    rg_pc_en = 1'b1;
    rg_pc_d_in = 64'h8000_0004;
    snap();
    chk("arm_no_err", 64'(err_any), 64'd0);
    chk("pcupd_1", 64'(pc_upd_cnt), 64'd1);
    rg_pc = 64'h8000_0004;
    rg_pc_en = 1'b1;
    rg_pc_d_in = 64'h8000_0004;
    snap();
    chk("pc_match", 64'(err_pc), 64'd0);
    rg_pc = 64'h8000_0008;
    snap();
    chk("pc_mismatch", 64'(err_pc), 64'd1);
    chk("first_pc_1", first_err_pc, 64'h8000_0008);
    chk("err_any_1", 64'(err_any), 64'd1);
    chk("pcupd_2", 64'(pc_upd_cnt), 64'd2);

    // Invalid cycle must be ignored
    rg_eepoch = 1'b1;
    idle();
    rg_eepoch = 1'b0;
    chk("invalid_frozen", 64'(err_eepoch), 64'd0);

    // eEpoch toggle requested but missing
    en_upd_eepoch = 1'b1;
    snap();
    chk("ee_ok_0", 64'(err_eepoch), 64'd0);
    snap();
    chk("ee_missing", 64'(err_eepoch), 64'd1);
    chk("first_pc_kept", first_err_pc, 64'h8000_0008);

    clear_err = 1'b1;
    idle();
    chk("clr_err_any", 64'(err_any), 64'd0);
    chk("clr_first_pc", first_err_pc, 64'd0);

    en_upd_eepoch = 1'b1;
    snap();
    rg_eepoch = 1'b1;
    snap();
    chk("ee_toggled", 64'(err_eepoch), 64'd0);
    snap();
    chk("ee_steady", 64'(err_any), 64'd0);

    // Flush and PC update together, then saturate
    rg_pc_en = 1'b1;
    rg_pc_d_in = 64'h100;
    ma_flush = 1'b1;
    snap();
    chk("both_flush", 64'(flush_cnt), 64'd1);
    chk("both_pcupd", 64'(pc_upd_cnt), 64'd3);
    rg_pc = 64'h100;
    for (int i = 0; i < 20; i++) begin
      ma_flush = 1'b1;
      snap();
    end
    chk("pc_after_both", 64'(err_pc), 64'd0);
    chk("flush_sat", 64'(flush_cnt), 64'd15);
    clear_err = 1'b1;
    idle();
    chk("flush_keep", 64'(flush_cnt), 64'd15);
    chk("pcupd_keep", 64'(pc_upd_cnt), 64'd3);

    // Fence held 1023 snapshots then dropped
    rg_fence = 1'b1;
    snap();
    chk("fence_enter", 64'(fsm_state), 64'd1);
    for (int i = 1; i < 1023; i++) snap();
    chk("fence_1023", 64'(fsm_state), 64'd1);
    chk("fence_1023_err", 64'(err_fence_tmo), 64'd0);
    rg_fence = 1'b0;
    snap();
    chk("fence_drop", 64'(fsm_state), 64'd0);
    chk("fence_drop_err", 64'(err_any), 64'd0);

    // Fence held 1024 snapshots -> timeout
    rg_fence = 1'b1;
    for (int i = 0; i < 1024; i++) snap();
    chk("tmo_state", 64'(fsm_state), 64'd3);
    chk("tmo_err", 64'(err_fence_tmo), 64'd1);
    chk("tmo_first_pc", first_err_pc, 64'h100);
    rg_fence = 1'b0;
    snap();
    chk("tmo_exit", 64'(fsm_state), 64'd0);
    chk("tmo_sticky", 64'(err_fence_tmo), 64'd1);
    rg_sfence = 1'b1;
    snap();
    chk("sfence_enter", 64'(fsm_state), 64'd2);
    rg_sfence = 1'b0;
    snap();
    chk("sfence_exit", 64'(fsm_state), 64'd0);

    // err_pc, then err_wepoch, then clear vs new violation
    clear_err = 1'b1;
    idle();
    rg_pc_en = 1'b1;
    rg_pc_d_in = 64'h200;
    snap();
    rg_pc = 64'h204;
    snap();
    chk("pc_err_2", 64'(err_pc), 64'd1);
    chk("first_pc_2", first_err_pc, 64'h204);
    rg_wepoch = 1'b1;
    snap();
    chk("we_err", 64'(err_wepoch), 64'd1);
    chk("first_pc_hold", first_err_pc, 64'h204);
    rg_wepoch = 1'b0;
    clear_err = 1'b1;
    snap();
    chk("clr_same_any", 64'(err_any), 64'd0);
    chk("clr_same_we", 64'(err_wepoch), 64'd0);
    chk("clr_same_pc", 64'(err_pc), 64'd0);
    chk("clr_same_first", first_err_pc, 64'd0);

    // Reset while in FENCE with PC check pending
    rg_fence = 1'b1;
    rg_pc_en = 1'b1;
    rg_pc_d_in = 64'h300;
    snap();
    chk("pre_rst_fsm", 64'(fsm_state), 64'd1);
    RST_N = 1'b0;
    idle();
    chk("mid_rst_fsm", 64'(fsm_state), 64'd0);
    chk("mid_rst_any", 64'(err_any), 64'd0);
    chk("mid_rst_flush", 64'(flush_cnt), 64'd0);
    chk("mid_rst_pcupd", 64'(pc_upd_cnt), 64'd0);
    chk("mid_rst_first", first_err_pc, 64'd0);
    RST_N = 1'b1;
    rg_fence = 1'b0;
    rg_pc = 64'h999;
    rg_eepoch = 1'b0;
    rg_wepoch = 1'b1;
    snap();
    chk("post_rst_any", 64'(err_any), 64'd0);
    chk("post_rst_fsm", 64'(fsm_state), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
